// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded operands, resolves forwarding selects
// and detects load-use hazards. Revision: 1.0
`default_nettype none

module id_ex_pipe_reg (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  output logic         id_ready,
  input  logic [4:0]   id_rs1,
  input  logic [4:0]   id_rs2,
  input  logic         id_rs1_ren,
  input  logic         id_rs2_ren,
  input  logic [4:0]   id_rd,
  input  logic         id_rd_wen,
  input  logic         id_is_load,
  input  logic [63:0]  id_src1,
  input  logic [63:0]  id_src2,
  input  logic [191:0] id_payload,
  input  logic         flush,
  input  logic [4:0]   mem_rd,
  input  logic         mem_rd_wen,
  input  logic [4:0]   wb_rd,
  input  logic         wb_rd_wen,
  input  logic [63:0]  wb_x_rd,
  input  logic         ex_ready,
  output logic         ex_valid,
  output logic [4:0]   ex_rd,
  output logic         ex_rd_wen,
  output logic         ex_is_load,
  output logic [191:0] ex_payload,
  output logic [63:0]  ex_exu_src1,
  output logic [63:0]  ex_exu_src2,
  output logic         exu_src1_forward_ex,
  output logic         exu_src2_forward_ex,
  output logic         exu_src1_forward_mem,
  output logic         exu_src2_forward_mem,
  output logic         load_use_stall
);

  logic rs1_live, rs2_live;
  logic hit1_ex, hit2_ex, hit1_mem, hit2_mem, hit1_wb, hit2_wb;
  logic bubble;

  // x0 and unread sources never match any producer
  assign rs1_live = id_rs1_ren && (id_rs1 != 5'd0);
  assign rs2_live = id_rs2_ren && (id_rs2 != 5'd0);

  assign hit1_ex  = rs1_live && ex_valid && ex_rd_wen && (ex_rd == id_rs1);
  assign hit2_ex  = rs2_live && ex_valid && ex_rd_wen && (ex_rd == id_rs2);
  assign hit1_mem = rs1_live && mem_rd_wen && (mem_rd == id_rs1);
  assign hit2_mem = rs2_live && mem_rd_wen && (mem_rd == id_rs2);
  assign hit1_wb  = rs1_live && wb_rd_wen && (wb_rd == id_rs1);
  assign hit2_wb  = rs2_live && wb_rd_wen && (wb_rd == id_rs2);

  assign load_use_stall = id_valid && ex_valid && ex_is_load && (hit1_ex || hit2_ex);
  assign id_ready       = ex_ready && (flush || !load_use_stall);
  assign bubble         = flush || load_use_stall;

  always_ff @(posedge clk) begin
    if (rst || (ex_ready && bubble)) begin
      ex_valid             <= 1'b0;
      ex_rd                <= 5'd0;
      ex_rd_wen            <= 1'b0;
      ex_is_load           <= 1'b0;
      ex_payload           <= 192'd0;
      ex_exu_src1          <= 64'd0;
      ex_exu_src2          <= 64'd0;
      exu_src1_forward_ex  <= 1'b0;
      exu_src2_forward_ex  <= 1'b0;
      exu_src1_forward_mem <= 1'b0;
      exu_src2_forward_mem <= 1'b0;
    end else if (ex_ready) begin
      ex_valid             <= id_valid;
      ex_rd                <= id_rd;
      ex_rd_wen            <= id_valid && id_rd_wen;
      ex_is_load           <= id_valid && id_is_load;
      ex_payload           <= id_payload;
      exu_src1_forward_ex  <= id_valid && hit1_ex;
      exu_src2_forward_ex  <= id_valid && hit2_ex;
      exu_src1_forward_mem <= id_valid && !hit1_ex && hit1_mem;
      exu_src2_forward_mem <= id_valid && !hit2_ex && hit2_mem;
      // WB data is folded into the operand here; EX/MEM results arrive later via the EX mux
      ex_exu_src1          <= (hit1_wb && !hit1_ex && !hit1_mem) ? wb_x_rd : id_src1;
      ex_exu_src2          <= (hit2_wb && !hit2_ex && !hit2_mem) ? wb_x_rd : id_src2;
    end
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Single clock, reset synchronous and active-high; all state updates on rising edge of clk.
REQ-002 clk  in  1  core clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 id_valid  in  1  ID holds a valid decoded instruction.
REQ-005 id_ready  out  1  ID instruction accepted this cycle.
REQ-006 id_rs1 / id_rs2  in  5 each  source register indices.
REQ-007 id_rs1_ren / id_rs2_ren  in  1 each  instruction actually reads rs1 / rs2.
REQ-008 id_rd  in  5  destination index.
REQ-009 id_rd_wen  in  1  instruction writes rd.
REQ-010 id_is_load  in  1  instruction is a load.
REQ-011 id_src1 / id_src2  in  64 each  regfile read data (or immediate/pc already muxed by ID).
REQ-012 id_payload  in  192  opaque pc/imm/control bundle, passed through unmodified.
REQ-013 flush  in  1  branch/exception redirect from EX; asserted only while ex_ready=1.
REQ-014 mem_rd  in  5  rd of instruction currently in MEM.
REQ-015 mem_rd_wen  in  1  MEM instruction valid and writes rd.
REQ-016 wb_rd  in  5  rd of instruction currently in WB.
REQ-017 wb_rd_wen  in  1  WB instruction valid and writes rd this cycle.
REQ-018 wb_x_rd  in  64  WB write-back data.
REQ-019 ex_ready  in  1  EX can advance; 0 freezes this register.
REQ-020 ex_valid  out  1  EX-stage instruction valid.
REQ-021 ex_rd / ex_rd_wen / ex_is_load  out  5/1/1  registered copies of ID fields.
REQ-022 ex_payload  out  192  registered id_payload.
REQ-023 ex_exu_src1 / ex_exu_src2  out  64 each  registered operands, feeding the EX forwarding mux.
REQ-024 exu_src1_forward_ex / exu_src2_forward_ex  out  1 each  EX mux selects mem_x_rd.
REQ-025 exu_src1_forward_mem / exu_src2_forward_mem  out  1 each  EX mux selects wb_x_rd.
REQ-026 load_use_stall  out  1  combinational load-use hazard indicator.

Function
REQ-027 hitN(stage) := id_rsN_ren && id_rsN!=0 && stage_rd_wen && stage_rd==id_rsN; the EX-stage term also requires ex_valid.
REQ-028 load_use_stall = id_valid && ex_valid && ex_is_load && (hit1(ex) || hit2(ex)).
REQ-029 id_ready = ex_ready && (flush || !load_use_stall).
REQ-030 ex_ready=0: all registers hold, regardless of any other input.
REQ-031 ex_ready=1, priority flush > load_use_stall > advance.
REQ-032 Flush or stall: insert bubble next cycle -- ex_valid, ex_rd_wen, ex_is_load, all four forward flags <=0; ex_rd, operands, payload <=0.
REQ-033 Advance: ex_valid<=id_valid; ex_rd, ex_rd_wen, ex_is_load, ex_payload captured; rd_wen/is_load gated by id_valid.
REQ-034 Advance, per source N: exu_srcN_forward_ex <= id_valid && hitN(ex).
REQ-035 Advance: exu_srcN_forward_mem <= id_valid && !hitN(ex) && hitN(mem).
REQ-036 Advance: ex_exu_srcN <= wb_x_rd if hitN(wb) && !hitN(ex) && !hitN(mem), else id_srcN.
REQ-037 Priority EX > MEM > WB; flags _ex and _mem never both 1 for one source.
REQ-038 x0 never forwarded; rsN_ren=0 never forwards.
REQ-039 Latency one cycle ID->EX; load-use costs exactly one bubble, after which the load sits in MEM and the dependent instruction takes the _mem path.

Reset
REQ-040 rst=1 at a clock edge clears all registered outputs to 0, overriding ex_ready and flush.
REQ-041 rst mid-operation discards the held instruction; first cycle after reset release ex_valid=0.

Verification
REQ-042 Back-to-back: add x5 (rd=5) then id rs1=5 with ex_ready=1 -> next cycle exu_src1_forward_ex=1, forward_mem=0.
REQ-043 Load-use: ex holds load rd=7, ID rs2=7, rs2_ren=1 -> load_use_stall=1, id_ready=0; next cycle ex_valid=0; following cycle exu_src2_forward_mem=1.
REQ-044 WB bypass: wb_rd=3, wb_rd_wen=1, wb_x_rd=0xDEAD, ID rs1=3, no EX/MEM hit -> ex_exu_src1=0xDEAD, all flags 0.
REQ-045 Priority/x0: EX and MEM both write rd=4, ID rs1=4 -> forward_ex=1, forward_mem=0; ID rs1=0 with rd=0 writers -> all flags 0.
REQ-046 Freeze/flush: ex_ready=0 for 3 cycles with changing ID inputs -> outputs constant; then flush=1, ex_ready=1 -> next cycle ex_valid=0, flags 0, id_ready was 1.
